move_controller: RTL and testbench
==================================

// Module: move_controller
// PURPOSE
//  Turn/selection controller that owns the 8x8 board register. Takes square clicks from the UI,
//  selects the side-to-move's piece and drives figure_move_logic with it (selected_figure, sel_pos).
//  After a fixed wait it latches the returned possible_moves mask and validates the target click.
//  On a legal target it commits the move, handles pawn promotion and king capture, and toggles turn.
// PARAMETERS
//  MASK_WAIT  1  cycles from selection until possible_moves is sampled (>=1)
//  PROMO_EN   1  1: pawn on last row becomes queen (5 white / 11 black); 0: stays pawn
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       asynchronous reset, active low
//  new_game         in   1       sync pulse: reload initial board, white to move (beats click)
//  click            in   1       one-cycle pulse, square selected by user
//  click_pos        in   6       [5:3] row, [2:0] col; valid with click
//  possible_moves   in   64      mask from figure_move_logic, bit row*8+col
//  selected_figure  out  5       code of selected piece, 0 when none
//  sel_pos          out  6       square of selected piece
//  sel_valid        out  1       piece selected (SEL_WAIT or ARMED)
//  moves_q          out  64      latched, own-colour-filtered mask (for highlight)
//  board            out  4x8x8   [row][col] piece codes, 0 empty
//  turn             out  1       0 white, 1 black to move
//  move_done        out  1       one-cycle pulse after board write
//  illegal_click    out  1       one-cycle pulse on rejected click
//  game_over        out  1       sticky until new_game/reset
//  winner           out  1       side that captured king; valid with game_over
// BEHAVIOUR
//  Codes: pawn1 bishop2 knight3 rook4 queen5 king6 (white); +6 black (7..12); 13-15 never written.
//  Own piece: turn=0 -> code 1..6, turn=1 -> 7..12.
//  Reset / new_game: row0 = 4,3,2,5,6,2,3,4 (col0..7); row1 all 1; rows2-5 0; row6 all 7;
//   row7 = 10,9,8,11,12,8,9,10. All other outputs 0; state IDLE.
//   Async reset from any state, including mid-COMMIT: no partial board write survives.
//  FSM IDLE, SEL_WAIT, ARMED, COMMIT, OVER:
//   IDLE:     click on own piece -> latch sel_pos, selected_figure=board code, -> SEL_WAIT.
//             Any other click -> illegal_click next cycle, stay.
//   SEL_WAIT: count MASK_WAIT cycles; on last cycle latch
//             moves_q = possible_moves & ~own_mask; -> ARMED. Clicks ignored, no illegal pulse.
//   ARMED:    click == sel_pos -> deselect (selected_figure=0, moves_q=0), -> IDLE.
//             click on other own piece -> reselect, -> SEL_WAIT (counter restarts).
//             moves_q[click_pos]=1 -> latch dst, -> COMMIT.
//             else -> illegal_click pulse, stay ARMED.
//   COMMIT:   single cycle. board[dst]=piece (promoted if PROMO_EN and pawn reaches row7 white
//             / row0 black), board[src]=0. If captured code is 6 or 12: game_over=1,
//             winner=turn, -> OVER. Else turn toggles, -> IDLE. Both paths: move_done=1 next
//             cycle; selected_figure, sel_valid, moves_q cleared.
//   OVER:     all clicks ignored (no illegal pulse); only new_game/reset leave.
//  Latency: IDLE click at cycle N -> sel_valid at N+1, ARMED at N+1+MASK_WAIT.
//   Legal ARMED click at N -> COMMIT at N+1, board updated and move_done at N+2.
//  new_game in any state same edge as click: new_game wins, click dropped.
//  Pulse outputs never high two consecutive cycles from one click.
// TESTING
//  1 Reset then release -> board equals initial layout, turn=0, all pulses/flags 0.
//  2 Click 0x0C (row1,col4), model mask bits 20,28 -> ARMED at N+2; click 0x1C ->
//    board[3][4]=1, board[1][4]=0, move_done at N+2, turn=1.
//  3 White turn, click black pawn 0x30 -> illegal_click 1 cycle, state IDLE, board unchanged.
//  4 ARMED, click square with mask bit 0 -> illegal pulse, stay ARMED;
//    click sel_pos -> deselected, IDLE.
//  5 Preload white pawn row6, mask allows row7 capture of king 12 -> board shows 5,
//    game_over=1, winner=0; later clicks ignored.
//  6 new_game asserted same cycle as legal target click -> initial board, no move_done;
//    rst_n low during COMMIT -> initial board.

Source files
------------

// File: rtl/move_controller.sv
// Turn/selection controller owning the 8x8 board register.
// Selects the side-to-move's piece, samples the move mask after a fixed wait,
// validates the target click, commits the move (with promotion) and detects
// king capture.
module move_controller #(
   parameter int unsigned MASK_WAIT = 1,
   parameter bit          PROMO_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  new_game,
   input  logic                  click,
   input  logic [5:0]            click_pos,
   input  logic [63:0]           possible_moves,
   output logic [4:0]            selected_figure,
   output logic [5:0]            sel_pos,
   output logic                  sel_valid,
   output logic [63:0]           moves_q,
   output logic [7:0][7:0][3:0]  board,
   output logic                  turn,
   output logic                  move_done,
   output logic                  illegal_click,
   output logic                  game_over,
   output logic                  winner
);

   localparam int unsigned CW = (MASK_WAIT > 1) ? $clog2(MASK_WAIT) : 1;

   typedef enum logic [2:0] {IDLE, SEL_WAIT, ARMED, COMMIT, OVER} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [5:0]     dst;
   logic [63:0]    own_mask;
   logic [3:0]     click_code;
   logic           own_click;
   logic [3:0]     placed;
   logic [3:0]     captured;
   logic           king_hit;

   function automatic logic [7:0][7:0][3:0] init_board();
      logic [7:0][7:0][3:0] b;
      b = '0;
      b[0] = {4'd4, 4'd3, 4'd2, 4'd6, 4'd5, 4'd2, 4'd3, 4'd4};
      b[1] = {8{4'd1}};
      b[6] = {8{4'd7}};
      b[7] = {4'd10, 4'd9, 4'd8, 4'd12, 4'd11, 4'd8, 4'd9, 4'd10};
      return b;
   endfunction

   function automatic logic is_own(input logic [3:0] code, input logic side);
      if (side) return (code >= 4'd7) && (code <= 4'd12);
      else      return (code >= 4'd1) && (code <= 4'd6);
   endfunction

   // Squares occupied by the side to move, and classification of the clicked square
   always_comb begin
      own_mask = '0;
      for (int unsigned r = 0; r < 8; r++)
         for (int unsigned c = 0; c < 8; c++)
            own_mask[r*8+c] = is_own(board[r][c], turn);
      click_code = board[click_pos[5:3]][click_pos[2:0]];
      own_click  = is_own(click_code, turn);
   end

   // Piece landing on dst (with promotion) and the piece it replaces
   always_comb begin
      placed = selected_figure[3:0];
      if (PROMO_EN && selected_figure[3:0] == 4'd1 && dst[5:3] == 3'd7) placed = 4'd5;
      if (PROMO_EN && selected_figure[3:0] == 4'd7 && dst[5:3] == 3'd0) placed = 4'd11;
      captured = board[dst[5:3]][dst[2:0]];
      king_hit = (captured == 4'd6) || (captured == 4'd12);
   end

   // Turn FSM; new_game takes priority over every click
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         dst             <= '0;
         sel_pos         <= '0;
         selected_figure <= '0;
         sel_valid       <= 1'b0;
         moves_q         <= '0;
         board           <= init_board();
         turn            <= 1'b0;
         move_done       <= 1'b0;
         illegal_click   <= 1'b0;
         game_over       <= 1'b0;
         winner          <= 1'b0;
      end else if (new_game) begin
         state           <= IDLE;
         cnt             <= '0;
         dst             <= '0;
         sel_pos         <= '0;
         selected_figure <= '0;
         sel_valid       <= 1'b0;
         moves_q         <= '0;
         board           <= init_board();
         turn            <= 1'b0;
         move_done       <= 1'b0;
         illegal_click   <= 1'b0;
         game_over       <= 1'b0;
         winner          <= 1'b0;
      end else begin
         move_done     <= 1'b0;
         illegal_click <= 1'b0;
         case (state)
            IDLE: begin
               if (click) begin
                  if (own_click) begin
                     sel_pos         <= click_pos;
                     selected_figure <= {1'b0, click_code};
                     sel_valid       <= 1'b1;
                     cnt             <= '0;
                     state           <= SEL_WAIT;
                  end else begin
                     illegal_click <= 1'b1;
                  end
               end
            end
            SEL_WAIT: begin
               if (cnt == CW'(MASK_WAIT - 1)) begin
                  moves_q <= possible_moves & ~own_mask;
                  state   <= ARMED;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ARMED: begin
               if (click) begin
                  if (click_pos == sel_pos) begin
                     selected_figure <= '0;
                     sel_valid       <= 1'b0;
                     moves_q         <= '0;
                     state           <= IDLE;
                  end else if (own_click) begin
                     sel_pos         <= click_pos;
                     selected_figure <= {1'b0, click_code};
                     moves_q         <= '0;
                     cnt             <= '0;
                     state           <= SEL_WAIT;
                  end else if (moves_q[click_pos]) begin
                     dst       <= click_pos;
                     sel_valid <= 1'b0;
                     state     <= COMMIT;
                  end else begin
                     illegal_click <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               board[dst[5:3]][dst[2:0]]         <= placed;
               board[sel_pos[5:3]][sel_pos[2:0]] <= 4'd0;
               move_done       <= 1'b1;
               selected_figure <= '0;
               sel_valid       <= 1'b0;
               moves_q         <= '0;
               if (king_hit) begin
                  game_over <= 1'b1;
                  winner    <= turn;
                  state     <= OVER;
               end else begin
                  turn  <= ~turn;
                  state <= IDLE;
               end
            end
            OVER: begin
               state <= OVER;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: vector table for the selection flow,
// hand-written sequences for capture/promotion, new_game and reset cases.
module tb_move_controller;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 new_game;
   logic                 click;
   logic [5:0]           click_pos;
   logic [63:0]          possible_moves;
   logic [4:0]           selected_figure;
   logic [5:0]           sel_pos;
   logic                 sel_valid;
   logic [63:0]          moves_q;
   logic [7:0][7:0][3:0] board;
   logic                 turn;
   logic                 move_done;
   logic                 illegal_click;
   logic                 game_over;
   logic                 winner;

   int unsigned checks = 0;
   int unsigned passed = 0;

   logic [7:0][7:0][3:0] mb;
   logic                 mturn;
   logic                 mover;

   move_controller #(.MASK_WAIT(1), .PROMO_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .new_game(new_game), .click(click),
      .click_pos(click_pos), .possible_moves(possible_moves),
      .selected_figure(selected_figure), .sel_pos(sel_pos), .sel_valid(sel_valid),
      .moves_q(moves_q), .board(board), .turn(turn), .move_done(move_done),
      .illegal_click(illegal_click), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ng;
      logic        ck;
      logic [5:0]  pos;
      logic [63:0] mask;
      logic        e_sv;
      logic        e_il;
      logic        e_md;
      logic        e_tn;
      logic [4:0]  e_sf;
      logic [63:0] e_mq;
   } vec_t;

   localparam logic [63:0] M1  = (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 8);
   localparam logic [63:0] M1F = (64'd1 << 20) | (64'd1 << 28);
   localparam logic [63:0] M2  = (64'd1 << 43) | (64'd1 << 35) | (64'd1 << 52);
   localparam logic [63:0] M2F = (64'd1 << 43) | (64'd1 << 35);

   vec_t tbl [20];

   function automatic logic [7:0][7:0][3:0] ref_init();
      logic [7:0][7:0][3:0] b;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[1][c] = 4'd1;
         b[6][c] = 4'd7;
      end
      b[0][0] = 4'd4;  b[0][1] = 4'd3; b[0][2] = 4'd2; b[0][3] = 4'd5;
      b[0][4] = 4'd6;  b[0][5] = 4'd2; b[0][6] = 4'd3; b[0][7] = 4'd4;
      b[7][0] = 4'd10; b[7][1] = 4'd9; b[7][2] = 4'd8; b[7][3] = 4'd11;
      b[7][4] = 4'd12; b[7][5] = 4'd8; b[7][6] = 4'd9; b[7][7] = 4'd10;
      return b;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      click    = 1'b0;
      new_game = 1'b0;
   endtask

   task automatic do_move(input logic [5:0] src, input logic [5:0] dsq);
      logic [3:0] piece;
      logic [3:0] cap;
      possible_moves = 64'd1 << dsq;
      click = 1'b1; click_pos = src;
      tick();
      chk($sformatf("mv%0h_sel", src), {255'd0, sel_valid}, 256'd1);
      tick();
      click = 1'b1; click_pos = dsq;
      tick();
      tick();
      piece = mb[src[5:3]][src[2:0]];
      if (piece == 4'd1 && dsq[5:3] == 3'd7) piece = 4'd5;
      if (piece == 4'd7 && dsq[5:3] == 3'd0) piece = 4'd11;
      cap = mb[dsq[5:3]][dsq[2:0]];
      mb[dsq[5:3]][dsq[2:0]] = piece;
      mb[src[5:3]][src[2:0]] = 4'd0;
      if (cap == 4'd6 || cap == 4'd12) mover = 1'b1;
      else mturn = ~mturn;
      chk($sformatf("mv%0h_done", dsq), {255'd0, move_done}, 256'd1);
      chk($sformatf("mv%0h_board", dsq), board, mb);
      chk($sformatf("mv%0h_turn", dsq), {255'd0, turn}, {255'd0, mturn});
      tick();
      chk($sformatf("mv%0h_done_low", dsq), {255'd0, move_done}, 256'd0);
   endtask

   initial begin
      rst_n = 1'b0; new_game = 1'b0; click = 1'b0; click_pos = '0; possible_moves = '0;
      mb = ref_init(); mturn = 1'b0; mover = 1'b0;

      //             ng    ck    pos    mask  sv    il    md    tn    sf     mq
      tbl[0]  = '{1'b0, 1'b1, 6'h30, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  64'd0};
      tbl[1]  = '{1'b0, 1'b0, 6'h00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'd0};
      tbl[2]  = '{1'b0, 1'b1, 6'h0C, M1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  64'd0};
      tbl[3]  = '{1'b0, 1'b0, 6'h00, M1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  M1F};
      tbl[4]  = '{1'b0, 1'b1, 6'h24, M1,    1'b1, 1'b1, 1'b0, 1'b0, 5'd1,  M1F};
      tbl[5]  = '{1'b0, 1'b1, 6'h1C, M1,    1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  M1F};
      tbl[6]  = '{1'b0, 1'b0, 6'h00, M1,    1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  64'd0};
      tbl[7]  = '{1'b0, 1'b0, 6'h00, M1,    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  64'd0};
      tbl[8]  = '{1'b0, 1'b1, 6'h33, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  64'd0};
      tbl[9]  = '{1'b0, 1'b1, 6'h10, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  M2F};
      tbl[10] = '{1'b0, 1'b1, 6'h10, M2,    1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  M2F};
      tbl[11] = '{1'b0, 1'b1, 6'h33, M2,    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  64'd0};
      tbl[12] = '{1'b0, 1'b1, 6'h20, M2,    1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  64'd0};
      tbl[13] = '{1'b0, 1'b1, 6'h3C, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 64'd0};
      tbl[14] = '{1'b0, 1'b0, 6'h00, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd12, M2F};
      tbl[15] = '{1'b0, 1'b1, 6'h34, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  64'd0};
      tbl[16] = '{1'b0, 1'b0, 6'h00, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  M2F};
      tbl[17] = '{1'b0, 1'b1, 6'h3C, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 64'd0};
      tbl[18] = '{1'b0, 1'b1, 6'h3C, M2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd12, M2F};
      tbl[19] = '{1'b0, 1'b1, 6'h3C, M2,    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  64'd0};

      // reset state
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      chk("rst_board", board, ref_init());
      chk("rst_turn", {255'd0, turn}, 256'd0);
      chk("rst_flags", {250'd0, sel_valid, move_done, illegal_click, game_over, winner, 1'b0}, 256'd0);
      chk("rst_selfig", {251'd0, selected_figure}, 256'd0);
      chk("rst_moves", {192'd0, moves_q}, 256'd0);

      // selection / validation flow
      for (int i = 0; i < 20; i++) begin
         new_game = tbl[i].ng; click = tbl[i].ck; click_pos = tbl[i].pos;
         possible_moves = tbl[i].mask;
         tick();
         chk($sformatf("v%0d_sv", i), {255'd0, sel_valid}, {255'd0, tbl[i].e_sv});
         chk($sformatf("v%0d_il", i), {255'd0, illegal_click}, {255'd0, tbl[i].e_il});
         chk($sformatf("v%0d_md", i), {255'd0, move_done}, {255'd0, tbl[i].e_md});
         chk($sformatf("v%0d_tn", i), {255'd0, turn}, {255'd0, tbl[i].e_tn});
         chk($sformatf("v%0d_sf", i), {251'd0, selected_figure}, {251'd0, tbl[i].e_sf});
         chk($sformatf("v%0d_mq", i), {192'd0, moves_q}, {192'd0, tbl[i].e_mq});
         if (i == 7) begin
            mb[3][4] = 4'd1; mb[1][4] = 4'd0; mturn = 1'b1;
            chk("first_move_board", board, mb);
         end
      end
      chk("table_board", board, mb);

      // walk a white pawn up to row 6, then capture the black king with promotion
      do_move(6'h30, 6'h28);
      do_move(6'h1C, 6'h24);
      do_move(6'h28, 6'h20);
      do_move(6'h24, 6'h2C);
      do_move(6'h20, 6'h18);
      do_move(6'h2C, 6'h34);
      do_move(6'h18, 6'h10);
      do_move(6'h34, 6'h3C);
      chk("promo_queen", {252'd0, board[7][4]}, 256'd5);
      chk("over_flag", {255'd0, game_over}, 256'd1);
      chk("over_winner", {255'd0, winner}, 256'd0);

      // game over: clicks ignored
      possible_moves = '1;
      click = 1'b1; click_pos = 6'h08;
      tick();
      chk("over_no_illegal", {255'd0, illegal_click}, 256'd0);
      chk("over_no_sel", {255'd0, sel_valid}, 256'd0);
      tick();
      chk("over_board_kept", board, mb);
      chk("over_sticky", {255'd0, game_over}, 256'd1);

      // new_game leaves OVER
      new_game = 1'b1;
      tick();
      chk("ng_board", board, ref_init());
      chk("ng_over_clr", {255'd0, game_over}, 256'd0);
      chk("ng_turn", {255'd0, turn}, 256'd0);

      // new_game on the same edge as a legal target click
      possible_moves = 64'd1 << 20;
      click = 1'b1; click_pos = 6'h0C;
      tick();
      tick();
      chk("ng2_armed_mq", {192'd0, moves_q}, {192'd0, 64'd1 << 20});
      click = 1'b1; click_pos = 6'h14; new_game = 1'b1;
      tick();
      chk("ng2_sv", {255'd0, sel_valid}, 256'd0);
      tick();
      chk("ng2_no_done", {255'd0, move_done}, 256'd0);
      chk("ng2_board", board, ref_init());
      chk("ng2_turn", {255'd0, turn}, 256'd0);

      // async reset while in COMMIT
      click = 1'b1; click_pos = 6'h0C;
      tick();
      tick();
      click = 1'b1; click_pos = 6'h14;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_commit_async", board, ref_init());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rst_commit_board", board, ref_init());
      chk("rst_commit_done", {255'd0, move_done}, 256'd0);
      chk("rst_commit_turn", {255'd0, turn}, 256'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
